// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment codes, field limits
// and the mapping from a display digit to the time field it comes from.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 6;

    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;
    localparam int MS10_MAX = 99;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        FLD_MS10 = 2'd0,
        FLD_SEC  = 2'd1,
        FLD_MIN  = 2'd2
    } field_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational decode of one display digit: picks the tens or ones BCD digit
// of a binary field and maps it to an active-low segment pattern.
module seg7_bcd_decode
    import stopwatch_pkg::*;
(
    input  logic [6:0] value,
    input  logic       in_range,
    input  logic       sel_tens,
    input  logic       blank_req,
    output logic [6:0] seg
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] digit;

    always_comb begin
        tens  = 4'(value / 7'd10);
        ones  = 4'(value % 7'd10);
        digit = sel_tens ? tens : ones;
        seg   = bcd_to_seg(digit);
        // An invalid field always shows dashes, even on a digit asking to blank
        if (!in_range) begin
            seg = SEG_DASH;
        end else if (blank_req && (digit == 4'd0)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/stopwatch_disp_scan.sv
// Six-digit multiplexed 7-segment driver for MM.SS.CC. Inputs are latched once
// per scan frame so every digit of a frame comes from the same counter value.
module stopwatch_disp_scan
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [6:0] ms_10_i,
    input  logic       blank_lead,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_reg;
    logic [2:0]    idx_reg;
    logic [5:0]    min_snap_reg;
    logic [5:0]    sec_snap_reg;
    logic [6:0]    ms_snap_reg;
    logic [5:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;

    logic          tick;
    logic          frame_end;
    logic [5:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [6:0]    fld_val [3];
    logic          fld_ok  [3];
    logic [6:0]    dig_seg [NUM_DIGITS];

    assign tick      = (presc_reg == PRESC_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);

    assign fld_val[FLD_MS10] = ms_snap_reg;
    assign fld_val[FLD_SEC]  = {1'b0, sec_snap_reg};
    assign fld_val[FLD_MIN]  = {1'b0, min_snap_reg};
    assign fld_ok[FLD_MS10]  = (ms_snap_reg  <= 7'(MS10_MAX));
    assign fld_ok[FLD_SEC]   = (sec_snap_reg <= 6'(SEC_MAX));
    assign fld_ok[FLD_MIN]   = (min_snap_reg <= 6'(MIN_MAX));

    // Digit pairs share a field: even digits show ones, odd digits show tens.
    // Only the minutes-tens digit honours leading-zero blanking.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam int FI       = gi / 2;
            localparam bit IS_TENS  = (gi % 2) == 1;
            localparam bit IS_LEAD  = (gi == NUM_DIGITS - 1);

            seg7_bcd_decode u_dec (
                .value     (fld_val[FI]),
                .in_range  (fld_ok[FI]),
                .sel_tens  (IS_TENS),
                .blank_req (IS_LEAD && blank_lead),
                .seg       (dig_seg[gi])
            );
        end
    endgenerate

    always_comb begin
        an_next  = 6'b111111;
        seg_next = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == 3'(i)) begin
                an_next[i] = 1'b0;
                seg_next   = dig_seg[i];
            end
        end
        dp_next = !((idx_reg == 3'd2) || (idx_reg == 3'd4));
    end

    // Anode, segments and dp all register on the same edge, so a digit never
    // briefly shows its neighbour's pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg    <= '0;
            idx_reg      <= 3'd0;
            min_snap_reg <= '0;
            sec_snap_reg <= '0;
            ms_snap_reg  <= '0;
            an_reg       <= 6'b111111;
            seg_reg      <= SEG_BLANK;
            dp_reg       <= 1'b1;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
            end
            if (frame_end) begin
                min_snap_reg <= min_i;
                sec_snap_reg <= sec_i;
                ms_snap_reg  <= ms_10_i;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an_o  = an_reg;
    assign seg_o = seg_reg;
    assign dp_o  = dp_reg;

endmodule
